// File: rtl/and_seq_ctrl.sv
// Two-requester round-robin sequencer that time-multiplexes one WIDTH-bit AND
// stage over N serial operand beats per job and returns the result with its owner id.
module and_seq_ctrl #(
    parameter int N     = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s0_valid,
    output logic             s0_ready,
    input  logic [WIDTH-1:0] s0_data,
    input  logic             s1_valid,
    output logic             s1_ready,
    input  logic [WIDTH-1:0] s1_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_id,
    output logic             busy
);

    localparam int            CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              rr_q, rr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic              sel_valid_s;
    logic [WIDTH-1:0]  sel_data_s;

    // State, arbitration and accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    // Next-state logic: grant in IDLE, fold beats in ACCUM, hand off in OUT.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        sel_valid_s = grant_q ? s1_valid : s0_valid;
        sel_data_s  = grant_q ? s1_data  : s0_data;
        case (state_q)
            IDLE: begin
                if (s0_valid || s1_valid) begin
                    if (s0_valid && s1_valid) begin
                        grant_d = rr_q;
                    end else begin
                        grant_d = s1_valid;
                    end
                    cnt_d   = '0;
                    acc_d   = '1;
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (sel_valid_s) begin
                    acc_d = acc_q & sel_data_s;
                    // The last beat leaves cnt at N-1 so it never wraps.
                    if (cnt_q == CNT_LAST) begin
                        state_d = OUT;
                        rr_d    = ~grant_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = ACCUM;
                end
            end
            OUT: begin
                if (m_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign s0_ready = (state_q == ACCUM) && !grant_q;
    assign s1_ready = (state_q == ACCUM) && grant_q;
    assign m_valid  = (state_q == OUT);
    assign m_data   = (state_q == OUT) ? acc_q : '0;
    assign m_id     = (state_q == OUT) && grant_q;
    assign busy     = (state_q == ACCUM) || (state_q == OUT);

endmodule

// File: tb/tb_and_seq_ctrl.sv
// Randomized and directed bench for and_seq_ctrl (N=3, WIDTH=4) with a job-level
// reference model compared against every output on every cycle.
module tb_and_seq_ctrl;
    localparam int N = 3;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         s0_valid, s0_ready, s1_valid, s1_ready;
    logic [W-1:0] s0_data, s1_data, m_data;
    logic         m_valid, m_ready, m_id, busy;

    and_seq_ctrl #(.N(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_id(m_id),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int q0[$];
    int q1[$];
    logic [4:0] obs[$];
    int mr_low = 0;
    bit mr_rand = 1'b0;
    int hs1n = 0;
    int first_mv = -1;
    int mv_cnt = 0;

    // Reference model: owner (-1 = none), beats taken, presenting flag.
    int owner = -1;
    int taken = 0;
    int pref = 0;
    bit pres = 1'b0;
    logic [3:0] andv = 4'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic drive();
        int h;
        if (q0.size() > 0 && q0[0] >= 0) begin
            h = q0[0]; s0_valid = 1'b1; s0_data = h[3:0];
        end else begin
            s0_valid = 1'b0; s0_data = 4'($urandom);
        end
        if (q1.size() > 0 && q1[0] >= 0) begin
            h = q1[0]; s1_valid = 1'b1; s1_data = h[3:0];
        end else begin
            s1_valid = 1'b0; s1_data = 4'($urandom);
        end
        m_ready = mr_rand ? 1'($urandom_range(0, 1)) : (mr_low == 0);
    endtask

    task automatic model_step();
        if (rst) begin
            owner = -1; pres = 1'b0; pref = 0; taken = 0; andv = 4'h0;
        end else if (owner < 0) begin
            if (s0_valid && s1_valid) owner = pref;
            else if (s0_valid) owner = 0;
            else if (s1_valid) owner = 1;
            taken = 0;
            andv = 4'hF;
        end else if (!pres) begin
            if ((owner == 0) ? s0_valid : s1_valid) begin
                andv = andv & ((owner == 0) ? s0_data : s1_data);
                taken++;
                if (taken == N) begin
                    pres = 1'b1;
                    pref = 1 - owner;
                end
            end
        end else if (m_ready) begin
            owner = -1; pres = 1'b0;
        end
    endtask

    task automatic tick();
        bit h0, h1, acc;
        @(negedge clk);
        acc = (owner >= 0) && !pres;
        chk("s0_ready", 32'(s0_ready), 32'(acc && owner == 0));
        chk("s1_ready", 32'(s1_ready), 32'(acc && owner == 1));
        chk("m_valid", 32'(m_valid), 32'(pres));
        chk("m_data", 32'(m_data), pres ? 32'(andv) : 32'd0);
        chk("m_id", 32'(m_id), pres ? 32'(owner) : 32'd0);
        chk("busy", 32'(busy), 32'(owner >= 0));
        if (m_valid && m_ready) obs.push_back({m_id, m_data});
        if (m_valid) mv_cnt++;
        if (m_valid && first_mv < 0) first_mv = cyc;
        h0 = s0_valid && s0_ready;
        h1 = s1_valid && s1_ready;
        if (m_valid && !m_ready && mr_low > 0) mr_low--;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        if (h1) hs1n++;
        if (q0.size() > 0) begin
            if (q0[0] < 0 || h0) void'(q0.pop_front());
        end
        if (q1.size() > 0) begin
            if (q1[0] < 0 || h1) void'(q1.pop_front());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin
            s0_valid = 1'($urandom); s1_valid = 1'($urandom);
            s0_data = 4'($urandom); s1_data = 4'($urandom);
            m_ready = 1'($urandom);
            tick();
        end
        rst = 1'b0;
        q0.delete(); q1.delete(); obs.delete();
        mr_low = 0; mr_rand = 1'b0; first_mv = -1; mv_cnt = 0;
    endtask

    task automatic run_until(input int budget);
        int k = 0;
        while ((q0.size() > 0 || q1.size() > 0 || owner >= 0) && k < budget) begin
            drive();
            tick();
            k++;
        end
        chk("drain_in_budget", 32'(k < budget), 32'd1);
    endtask

    task automatic push_job(input int which);
        for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                if (which == 0) q0.push_back(-1); else q1.push_back(-1);
            end
            if (which == 0) q0.push_back(int'($urandom_range(0, 15)));
            else q1.push_back(int'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        logic [3:0] ea [4];
        logic [3:0] eb [4];
        rst = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0;
        s0_data = 4'h0; s1_data = 4'h0; m_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset with random inputs, then a quiet cycle.
        do_reset();
        drive();
        tick();
        chk("rst_busy_lit", 32'(busy), 32'd0);
        chk("rst_mvalid_lit", 32'(m_valid), 32'd0);

        // Single job: 0xF & 0xB & 0x7 = 0x3 at cycle 4.
        do_reset();
        q0 = '{15, 11, 7};
        t0 = cyc;
        run_until(50);
        chk("single_mv_cycle", 32'(first_mv - t0), 32'd4);
        chk("single_count", 32'(obs.size()), 32'd1);
        if (obs.size() == 1) chk("single_result", 32'(obs[0]), 32'h03);

        // Contention: s0 wins first after reset.
        do_reset();
        q0 = '{14, 15, 15};
        q1 = '{5, 7, 13};
        run_until(50);
        chk("cont_count", 32'(obs.size()), 32'd2);
        if (obs.size() == 2) begin
            chk("cont_first", 32'(obs[0]), 32'h0E);
            chk("cont_second", 32'(obs[1]), 32'h15);
        end

        // Stalls between beats and backpressure in OUT.
        do_reset();
        q0 = '{15, -1, -1, 11, 7};
        mr_low = 5;
        run_until(50);
        chk("bp_count", 32'(obs.size()), 32'd1);
        if (obs.size() == 1) chk("bp_result", 32'(obs[0]), 32'h03);
        chk("bp_mvalid_cycles", 32'(mv_cnt), 32'd6);

        // Reset after two accepted zero beats; aborted job emits nothing.
        do_reset();
        q1 = '{0, 0, 0};
        hs1n = 0;
        for (int k = 0; k < 20 && hs1n < 2; k++) begin
            drive();
            tick();
        end
        chk("midrst_two_beats", 32'(hs1n), 32'd2);
        do_reset();
        q1 = '{15, 15, 15};
        run_until(50);
        chk("midrst_count", 32'(obs.size()), 32'd1);
        if (obs.size() == 1) chk("midrst_result", 32'(obs[0]), 32'h1F);

        // Round-robin persistence over four contended jobs.
        do_reset();
        for (int j = 0; j < 2; j++) begin
            ea[j] = 4'hF; eb[j] = 4'hF;
            for (int b = 0; b < N; b++) begin
                int d0, d1;
                d0 = int'($urandom_range(0, 15));
                d1 = int'($urandom_range(0, 15));
                q0.push_back(d0); q1.push_back(d1);
                ea[j] = ea[j] & d0[3:0];
                eb[j] = eb[j] & d1[3:0];
            end
        end
        run_until(100);
        chk("rr_count", 32'(obs.size()), 32'd4);
        if (obs.size() == 4) begin
            chk("rr_job0", 32'(obs[0]), 32'({1'b0, ea[0]}));
            chk("rr_job1", 32'(obs[1]), 32'({1'b1, eb[0]}));
            chk("rr_job2", 32'(obs[2]), 32'({1'b0, ea[1]}));
            chk("rr_job3", 32'(obs[3]), 32'({1'b1, eb[1]}));
        end

        // Random traffic with random consumer backpressure.
        do_reset();
        mr_rand = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if (q0.size() < 3 && $urandom_range(0, 2) == 0) push_job(0);
            if (q1.size() < 3 && $urandom_range(0, 2) == 0) push_job(1);
            drive();
            tick();
        end
        mr_rand = 1'b0;
        run_until(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
